// File: rtl/button_conditioner.sv
// N-channel push-button front end: synchroniser, debounce FSM, press/release strobes and a
// lowest-index-wins key event. Define BUTTON_AUTO_REPEAT_EN to build the hold-to-repeat strobes.
module button_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000,
  parameter int CODE_W          = $clog2(NUM_BTN + 1)
) (
  input  logic               hwclk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               key_valid,
  output logic [CODE_W-1:0]  key_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_PEND,
    ST_HELD,
    ST_RELEASE_PEND
  } state_t;

  logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTN-1:0] s;
  logic [NUM_BTN-1:0] ev;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= btn_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge hwclk) begin
      if (reset) begin
        state_q   <= ST_RELEASED;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // cnt only advances while below DEB_LAST, so it saturates by construction
    always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        ST_RELEASED: begin
          if (s[g]) begin
            state_d = ST_PRESS_PEND;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_PRESS_PEND: begin
          if (!s[g]) begin
            state_d = ST_RELEASED;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_HELD;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!s[g]) begin
            state_d = ST_RELEASE_PEND;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_RELEASE_PEND: begin
          if (s[g]) begin
            state_d = ST_HELD;
          end else if (cnt_q == DEB_LAST) begin
            state_d   = ST_RELEASED;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_RELEASED;
      endcase
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rcnt_q, rcnt_d;
    logic [RPT_W-1:0] rcnt_inc, rcnt_target;
    logic             rfirst_q, rfirst_d;
    logic             rpt_q, rpt_d;

    always_ff @(posedge hwclk) begin
      if (reset) begin
        rcnt_q   <= '0;
        rfirst_q <= 1'b1;
        rpt_q    <= 1'b0;
      end else begin
        rcnt_q   <= rcnt_d;
        rfirst_q <= rfirst_d;
        rpt_q    <= rpt_d;
      end
    end

    // Counts only on edges that stay in HELD; a release glitch freezes it, accepted release clears it
    always_comb begin
      rcnt_d      = rcnt_q;
      rfirst_d    = rfirst_q;
      rpt_d       = 1'b0;
      rcnt_inc    = rcnt_q + RPT_W'(1);
      rcnt_target = rfirst_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
      if (state_q == ST_HELD && state_d == ST_HELD) begin
        if (rcnt_inc == rcnt_target) begin
          rpt_d    = 1'b1;
          rcnt_d   = '0;
          rfirst_d = 1'b0;
        end else begin
          rcnt_d = rcnt_inc;
        end
      end else if (state_q == ST_RELEASE_PEND && state_d == ST_RELEASED) begin
        rcnt_d   = '0;
        rfirst_d = 1'b1;
      end
    end

    assign btn_repeat[g] = rpt_q;
`else
    assign btn_repeat[g] = 1'b0;
`endif
  end

  assign ev = btn_press | btn_repeat;

  always_comb begin
    key_code  = '0;
    key_valid = |ev;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (ev[i]) key_code = CODE_W'(i + 1);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: a run-length debounce model checked every cycle,
// plus directed scenarios with hand-computed strobe timing.
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RR = 3;
  localparam int CW = 3;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic          hwclk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic          key_valid;
  logic [CW-1:0] key_code;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CODE_W(CW)
  ) dut (
    .hwclk(hwclk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 hwclk = ~hwclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge hwclk);
      @(negedge hwclk);
    end
  endtask

  // Model: level flips once the synchronised input has disagreed with it for DB+1 edges in a row
  logic [NB-1:0] raw_s;
  logic          rst_s;
  bit            seen = 1'b0;
  logic [NB-1:0] hist [SS];
  logic [NB-1:0] s_m;
  int            run    [NB];
  int            held_n [NB];
  logic [NB-1:0] m_level, m_press, m_rel, m_rpt;
  logic [CW-1:0] m_code;

  always @(posedge hwclk) begin
    raw_s <= btn_raw;
    rst_s <= reset;
    seen  <= 1'b1;
  end

  initial begin
    for (int k = 0; k < SS; k++) hist[k] = '0;
    for (int c = 0; c < NB; c++) begin
      run[c] = 0;
      held_n[c] = 0;
    end
    m_level = '0;
    forever begin
      @(negedge hwclk);
      if (seen) begin
        m_press = '0;
        m_rel   = '0;
        m_rpt   = '0;
        if (rst_s) begin
          for (int k = 0; k < SS; k++) hist[k] = '0;
          for (int c = 0; c < NB; c++) begin
            run[c] = 0;
            held_n[c] = 0;
          end
          m_level = '0;
        end else begin
          s_m = hist[SS-1];
          for (int c = 0; c < NB; c++) begin
            if (m_level[c] && run[c] == 0 && s_m[c]) begin
              held_n[c]++;
              if (RPT_ON && (held_n[c] == RD || (held_n[c] > RD && (held_n[c] - RD) % RR == 0)))
                m_rpt[c] = 1'b1;
            end
            if (s_m[c] != m_level[c]) begin
              run[c]++;
              if (run[c] == DB + 1) begin
                m_level[c] = s_m[c];
                run[c] = 0;
                if (s_m[c]) m_press[c] = 1'b1;
                else begin
                  m_rel[c] = 1'b1;
                  held_n[c] = 0;
                end
              end
            end else begin
              run[c] = 0;
            end
          end
          for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = raw_s;
        end
        m_code = '0;
        for (int c = NB - 1; c >= 0; c--) if (m_press[c] | m_rpt[c]) m_code = CW'(c + 1);
        chk("model_level",   32'(btn_level),   32'(m_level));
        chk("model_press",   32'(btn_press),   32'(m_press));
        chk("model_release", 32'(btn_release), 32'(m_rel));
        chk("model_repeat",  32'(btn_repeat),  32'(m_rpt));
        chk("model_kvalid",  32'(key_valid),   32'(|(m_press | m_rpt)));
        chk("model_kcode",   32'(key_code),    32'(m_code));
      end
    end
  end

  logic [14:0] bounce_pat;

  initial begin
    // Reset with all buttons pressed
    reset = 1'b1;
    btn_raw = 5'b11111;
    step(2);
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_press", 32'(btn_press), 32'h0);
    chk("rst_kvalid", 32'(key_valid), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("post_rst_press", 32'(btn_press), 32'h0);
      chk("post_rst_level", 32'(btn_level), 32'h0);
    end
    step(1);
    chk("all_press", 32'(btn_press), 32'h1f);
    chk("all_level", 32'(btn_level), 32'h1f);
    chk("all_kcode", 32'(key_code), 32'd1);
    chk("all_kvalid", 32'(key_valid), 32'd1);
    btn_raw = '0;
    step(6);
    chk("all_rel_early", 32'(btn_release), 32'h0);
    step(1);
    chk("all_release", 32'(btn_release), 32'h1f);
    chk("all_rel_level", 32'(btn_level), 32'h0);
    chk("all_rel_kvalid", 32'(key_valid), 32'h0);
    step(1);
    chk("all_rel_once", 32'(btn_release), 32'h0);
    step(3);

    // Clean press on channel 1
    btn_raw[1] = 1'b1;
    step(6);
    chk("c1_press_early", 32'(btn_press), 32'h0);
    step(1);
    chk("c1_press", 32'(btn_press), 32'h02);
    chk("c1_kcode", 32'(key_code), 32'd2);
    chk("c1_kvalid", 32'(key_valid), 32'd1);
    chk("c1_level", 32'(btn_level), 32'h02);
    step(1);
    chk("c1_press_once", 32'(btn_press), 32'h0);

    // Three-cycle release glitch while held
    btn_raw[1] = 1'b0;
    step(3);
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("c1_glitch_rel", 32'(btn_release[1]), 32'h0);
    end
    chk("c1_glitch_level", 32'(btn_level), 32'h02);
    btn_raw[1] = 1'b0;
    step(6);
    chk("c1_rel_early", 32'(btn_release[1]), 32'h0);
    step(1);
    chk("c1_release", 32'(btn_release), 32'h02);
    chk("c1_rel_level", 32'(btn_level), 32'h0);
    step(2);

    // Bounce on channel 0
    bounce_pat = 15'b000000001110111;
    for (int i = 0; i < 15; i++) begin
      btn_raw[0] = bounce_pat[i];
      step(1);
      chk("c0_bounce_press", 32'(btn_press[0]), 32'h0);
      chk("c0_bounce_level", 32'(btn_level[0]), 32'h0);
    end

    // Simultaneous press on channels 2 and 3
    btn_raw[3:2] = 2'b11;
    step(6);
    chk("sim_press_early", 32'(btn_press), 32'h0);
    step(1);
    chk("sim_press", 32'(btn_press), 32'h0c);
    chk("sim_kcode", 32'(key_code), 32'd3);
    btn_raw = '0;
    step(7);
    chk("sim_release", 32'(btn_release), 32'h0c);
    step(2);

    // Reset while channel 2 is debouncing a press
    btn_raw[2] = 1'b1;
    step(4);
    reset = 1'b1;
    step(2);
    chk("mid_rst_press", 32'(btn_press), 32'h0);
    chk("mid_rst_level", 32'(btn_level), 32'h0);
    chk("mid_rst_release", 32'(btn_release), 32'h0);
    reset = 1'b0;
    step(6);
    chk("mid_rst_early", 32'(btn_press), 32'h0);
    step(1);
    chk("mid_rst_press2", 32'(btn_press), 32'h04);
    chk("mid_rst_kcode", 32'(key_code), 32'd3);
    btn_raw = '0;
    step(7);
    chk("mid_rst_release2", 32'(btn_release), 32'h04);
    step(2);

    // Hold channel 4 for auto-repeat
    btn_raw[4] = 1'b1;
    step(7);
    chk("c4_press", 32'(btn_press), 32'h10);
    chk("c4_kcode", 32'(key_code), 32'd5);
    step(7);
    chk("c4_rpt_early", 32'(btn_repeat), 32'h0);
    step(1);
    chk("c4_rpt1", 32'(btn_repeat), RPT_ON ? 32'h10 : 32'h0);
    chk("c4_rpt1_kcode", 32'(key_code), RPT_ON ? 32'd5 : 32'd0);
    chk("c4_rpt1_kvalid", 32'(key_valid), RPT_ON ? 32'd1 : 32'd0);
    step(2);
    chk("c4_rpt_gap", 32'(btn_repeat), 32'h0);
    step(1);
    chk("c4_rpt2", 32'(btn_repeat), RPT_ON ? 32'h10 : 32'h0);
    step(3);
    chk("c4_rpt3", 32'(btn_repeat), RPT_ON ? 32'h10 : 32'h0);
    chk("c4_rpt3_kcode", 32'(key_code), RPT_ON ? 32'd5 : 32'd0);
    btn_raw = '0;
    step(7);
    chk("c4_release", 32'(btn_release), 32'h10);
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised N-channel push-button front end, sitting between raw board pins (left/right/up/down/mode_pb and future buttons) and the image/sound control logic.
- Per channel: synchronises, debounces and classifies each button into a level, press/release strobes and optional auto-repeat strobes.
- Adds a priority-encoded key event (code + valid) so downstream FSMs consume one event per cycle.
- Generalises the fixed single-pulse button handling to any channel count and adds hold-to-repeat.

Parameters:
- NUM_BTN, 5, number of button channels (1..16).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to accept a level change (>=1).
- REPEAT_DELAY, 500000, cycles held after press before the first repeat strobe (>=1).
- REPEAT_RATE, 100000, cycles between subsequent repeat strobes (>=1).
- CODE_W, $clog2(NUM_BTN+1), width of key_code.

Ports:
- hwclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  NUM_BTN  asynchronous raw button levels; 1 = pressed.
- btn_level  out  NUM_BTN  debounced level per channel.
- btn_press  out  NUM_BTN  one-cycle strobe on an accepted 0->1 change.
- btn_release  out  NUM_BTN  one-cycle strobe on an accepted 1->0 change.
- btn_repeat  out  NUM_BTN  one-cycle auto-repeat strobe (all zero when the macro is off).
- key_valid  out  1  a press or repeat event exists this cycle.
- key_code  out  CODE_W  (index+1) of the lowest-index channel with press|repeat; 0 when none.

Behaviour:
- Clock is one clock, hwclk. Reset is synchronous and active-high (reset sampled on the hwclk rising edge).
- Reset: synchroniser flops, counters and all outputs are 0; every channel FSM goes to RELEASED.
- Reset asserted mid-debounce or mid-hold abandons the operation. No strobe fires on reset entry or exit.
- Synchroniser: btn_raw passes through SYNC_STAGES flops. The output of the last stage is s.
- Per-channel FSM: RELEASED, PRESS_PEND, HELD, RELEASE_PEND. Debounce counter cnt is $clog2(DEBOUNCE_CYCLES+1) bits.
  - RELEASED: s=1 -> PRESS_PEND, cnt=1.
  - PRESS_PEND: s=0 -> RELEASED, cnt=0 (bounce rejected).
  - PRESS_PEND: s=1 and cnt==DEBOUNCE_CYCLES -> HELD, btn_press strobe, btn_level=1.
  - PRESS_PEND: otherwise cnt++.
  - HELD and RELEASE_PEND are symmetric with s inverted; the accepting transition raises btn_release and sets btn_level=0.
- Latency: raw held high from edge E gives btn_press high in the cycle after edge E+SYNC_STAGES+DEBOUNCE_CYCLES.
  - With SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 that is 6 edges. A one-cycle raw pulse never produces a press.
- btn_level changes on the same edge that raises the strobe. Strobes are registered and last exactly one cycle.
- Channels are fully independent. Simultaneous presses on several channels assert all their btn_press bits in the same cycle.
- key_code/key_valid are combinational from the registered strobes. Lowest index wins; other channels' events are visible only in btn_press/btn_repeat, with no queueing.
- Counters saturate and never wrap. A held level in HELD/RELEASED keeps cnt at 0.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter starts at 0 on entry and increments each cycle.
  - On reaching REPEAT_DELAY, btn_repeat strobes and the counter reloads. Thereafter it strobes every REPEAT_RATE cycles.
  - Entering RELEASE_PEND freezes the counter. Returning to HELD from RELEASE_PEND resumes the count. Acceptance of release clears it.
  - Repeat strobes participate in key_valid/key_code.
- Undefined: the repeat counters are absent, btn_repeat is tied to 0, and key events come from btn_press only.

Test Plan:
- Reset: reset high 2 cycles with btn_raw=5'b11111 -> all outputs 0 during reset and for SYNC_STAGES+DEBOUNCE_CYCLES cycles after. Then btn_press=5'b11111 for one cycle, with key_code=1.
- Clean press (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): btn_raw[1] high at edge 10 and held -> btn_press[1] high only after edge 16, btn_level[1]=1 from then, key_code=2, key_valid=1 for that cycle.
- Bounce: btn_raw[0] high 3 cycles, low 1, high 3, low -> no btn_press, btn_level[0] stays 0. A release glitch of 3 cycles while HELD -> no btn_release.
- Simultaneous: btn_raw[3] and btn_raw[2] rise on the same edge -> btn_press=5'b01100 in one cycle, key_code=3.
- Release/reset mid-op: held button released -> btn_release after 6 edges. Reset asserted while a channel is in PRESS_PEND with cnt=2 -> no strobe; after deassert the full 6-edge latency repeats.
- Auto-repeat (macro defined, REPEAT_DELAY=8, REPEAT_RATE=3): hold channel 4 -> btn_repeat[4] strobes 8 cycles after btn_press[4], then every 3 cycles, each with key_code=5. With the macro undefined, btn_repeat stays 0.
